multicycle_ctrl: RTL and testbench

- Control FSM that sequences the LoongArch CPU datapath through IF/ID/EXE/MEM/WB.
- Issues fetch and data requests and waits on ready handshakes from inst/data SRAM ports.
- Generates one-cycle write-enable pulses for IR, PC, regfile and data store.
- Keeps cycle/retired-instruction counters and halts on a memory-timeout error.

---
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl : IF/ID/EXE/MEM/WB sequencer for a multicycle LoongArch core
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_ready,
  input  logic        data_ready,
  input  logic        is_br_only,
  input  logic        is_link,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_alu,
  output logic        inst_req,
  output logic        ir_we,
  output logic        data_req,
  output logic        data_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        retire,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic [31:0]       instret_cnt_q, instret_cnt_d;

  logic inst_req_c, ir_we_c, data_req_c, data_we_c, rf_we_c, pc_we_c, retire_c;
  logic waiting;
  logic wait_hit;

  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    wait_cnt_d = '0;
    inst_req_c = 1'b0;
    ir_we_c    = 1'b0;
    data_req_c = 1'b0;
    data_we_c  = 1'b0;
    rf_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    retire_c   = 1'b0;
    waiting    = 1'b0;
    wait_hit   = (TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_C);

    case (state_q)
      S_IF: begin
        inst_req_c = 1'b1;
        if (inst_ready) begin
          ir_we_c = 1'b1;
          state_d = S_ID;
        end else begin
          waiting = 1'b1;
        end
      end
      S_ID: begin
        if (is_br_only) begin
          pc_we_c  = 1'b1;
          retire_c = 1'b1;
          state_d  = S_IF;
        end else if (!(is_link | is_load | is_store | is_alu)) begin
          // Unclassified instruction retires as a nop and is flagged
          illegal_d = 1'b1;
          pc_we_c   = 1'b1;
          retire_c  = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        state_d = (is_load | is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        data_req_c = 1'b1;
        data_we_c  = is_store;
        if (data_ready) begin
          if (is_store) begin
            pc_we_c  = 1'b1;
            retire_c = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        rf_we_c  = 1'b1;
        pc_we_c  = 1'b1;
        retire_c = 1'b1;
        state_d  = S_IF;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IF;
      end
    endcase

    // A ready on the timeout cycle never reaches here, so it wins over the halt
    if (waiting) begin
      if (wait_hit) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + TO_W'(1);
      end
    end

    cycle_cnt_d   = (state_q != S_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    instret_cnt_d = instret_cnt_q + {31'd0, retire_c};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IF;
      wait_cnt_q    <= '0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      halted_q      <= halted_d;
      illegal_q     <= illegal_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  // Everything is forced low while reset is held so a pending request is dropped
  assign inst_req    = !reset & inst_req_c;
  assign ir_we       = !reset & ir_we_c;
  assign data_req    = !reset & data_req_c;
  assign data_we     = !reset & data_we_c;
  assign rf_we       = !reset & rf_we_c;
  assign pc_we       = !reset & pc_we_c;
  assign retire      = !reset & retire_c;
  assign state       = reset ? 3'd0 : state_q;
  assign halted      = !reset & halted_q;
  assign illegal     = !reset & illegal_q;
  assign cycle_cnt   = reset ? 32'd0 : cycle_cnt_q;
  assign instret_cnt = reset ? 32'd0 : instret_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl : directed self-checking bench for multicycle_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_ready, data_ready, is_br_only, is_link, is_load, is_store, is_alu;
  logic        inst_req, ir_we, data_req, data_we, rf_we, pc_we, retire;
  logic [2:0]  state;
  logic        halted, illegal;
  logic [31:0] cycle_cnt, instret_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .inst_ready(inst_ready), .data_ready(data_ready),
    .is_br_only(is_br_only), .is_link(is_link), .is_load(is_load),
    .is_store(is_store), .is_alu(is_alu),
    .inst_req(inst_req), .ir_we(ir_we), .data_req(data_req), .data_we(data_we),
    .rf_we(rf_we), .pc_we(pc_we), .retire(retire), .state(state),
    .halted(halted), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // {inst_req, ir_we, data_req, data_we, rf_we, pc_we, retire, state[2:0]}
  wire [9:0] obs = {inst_req, ir_we, data_req, data_we, rf_we, pc_we, retire, state};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {inst_ready, data_ready, is_br_only, is_link, is_load, is_store, is_alu}
  task automatic apply(input logic [6:0] v);
    {inst_ready, data_ready, is_br_only, is_link, is_load, is_store, is_alu} = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(7'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(7'b1100001);
    step();
    #1;
    tests++;
    if (obs !== 10'b0) begin
      fails++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 10'b0);
    end
    tests++;
    if ({halted, illegal, cycle_cnt, instret_cnt} !== 66'd0) begin
      fails++; $display("FAIL reset_status halted=%b illegal=%b cyc=%0d ret=%0d exp all 0",
                        halted, illegal, cycle_cnt, instret_cnt);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_alu();
    logic [9:0] exp;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      apply(7'b1000001);
      #1;
      case ((c - 1) % 4)
        0:       exp = 10'b1100000_000;
        1:       exp = 10'b0000000_001;
        2:       exp = 10'b0000000_010;
        default: exp = 10'b0000111_100;
      endcase
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL alu_c%0d obs=%b exp=%b", c, obs, exp);
      end
      step();
    end
    tests++;
    if (instret_cnt !== 32'd3 || cycle_cnt !== 32'd12) begin
      fails++; $display("FAIL alu_counters ret=%0d cyc=%0d exp ret=3 cyc=12", instret_cnt, cycle_cnt);
    end
  endtask

  task automatic test_load_wait();
    logic [9:0] ex [0:7];
    ex = '{10'b1100000_000, 10'b0000000_001, 10'b0000000_010, 10'b0010000_011,
           10'b0010000_011, 10'b0010000_011, 10'b0010000_011, 10'b0000111_100};
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      apply((c == 7) ? 7'b1100100 : 7'b1000100);
      #1;
      tests++;
      if (obs !== ex[c-1]) begin
        fails++; $display("FAIL load_c%0d obs=%b exp=%b", c, obs, ex[c-1]);
      end
      step();
    end
    tests++;
    if (instret_cnt !== 32'd1 || cycle_cnt !== 32'd8) begin
      fails++; $display("FAIL load_counters ret=%0d cyc=%0d exp ret=1 cyc=8", instret_cnt, cycle_cnt);
    end
  endtask

  task automatic test_store_branch();
    logic [9:0] ex [0:5];
    ex = '{10'b1100000_000, 10'b0000000_001, 10'b0000000_010, 10'b0011011_011,
           10'b1100000_000, 10'b0000011_001};
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      apply((c <= 4) ? 7'b1100010 : 7'b1110000);
      #1;
      tests++;
      if (obs !== ex[c-1]) begin
        fails++; $display("FAIL stbr_c%0d obs=%b exp=%b", c, obs, ex[c-1]);
      end
      step();
    end
    tests++;
    if (instret_cnt !== 32'd2) begin
      fails++; $display("FAIL stbr_instret got=%0d exp=2", instret_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      apply(7'b0);
      #1;
      tests++;
      if (obs !== 10'b1000000_000) begin
        fails++; $display("FAIL to_if_c%0d obs=%b exp=%b", c, obs, 10'b1000000_000);
      end
      step();
    end
    tests++;
    if (obs !== 10'b0000000_101 || halted !== 1'b1 || cycle_cnt !== 32'd5) begin
      fails++; $display("FAIL to_halt obs=%b halted=%b cyc=%0d exp obs=0000000101 halted=1 cyc=5",
                        obs, halted, cycle_cnt);
    end
    apply(7'b1100001);
    step(); step(); step();
    tests++;
    if (obs !== 10'b0000000_101 || cycle_cnt !== 32'd5) begin
      fails++; $display("FAIL to_frozen obs=%b cyc=%0d exp obs=0000000101 cyc=5", obs, cycle_cnt);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== 10'b0 || halted !== 1'b0) begin
      fails++; $display("FAIL to_in_reset obs=%b halted=%b exp 0", obs, halted);
    end
    step();
    reset = 1'b0;
    #1;
    tests++;
    if (state !== 3'd0 || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0 || halted !== 1'b0) begin
      fails++; $display("FAIL to_after_reset st=%0d cyc=%0d ret=%0d halted=%b exp 0",
                        state, cycle_cnt, instret_cnt, halted);
    end
  endtask

  task automatic test_ready_at_timeout();
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      apply(7'b0);
      step();
    end
    apply(7'b1000001);
    #1;
    tests++;
    if (obs !== 10'b1100000_000) begin
      fails++; $display("FAIL rdy_to_fetch obs=%b exp=%b", obs, 10'b1100000_000);
    end
    step();
    tests++;
    if (state !== 3'd1 || halted !== 1'b0) begin
      fails++; $display("FAIL rdy_to_next st=%0d halted=%b exp st=1 halted=0", state, halted);
    end
  endtask

  task automatic test_illegal_reset_mem();
    do_reset();
    apply(7'b1000000);
    step();
    #1;
    tests++;
    if (obs !== 10'b0000011_001) begin
      fails++; $display("FAIL ill_id obs=%b exp=%b", obs, 10'b0000011_001);
    end
    step();
    tests++;
    if (illegal !== 1'b1 || state !== 3'd0 || instret_cnt !== 32'd1) begin
      fails++; $display("FAIL ill_flag illegal=%b st=%0d ret=%0d exp 1,0,1", illegal, state, instret_cnt);
    end
    apply(7'b1000100);
    for (int c = 0; c < 4; c++) step();
    tests++;
    if (obs !== 10'b0010000_011 || illegal !== 1'b1) begin
      fails++; $display("FAIL ill_mem_wait obs=%b illegal=%b exp obs=0010000011 illegal=1", obs, illegal);
    end
    reset = 1'b1;
    apply(7'b1100100);
    #1;
    tests++;
    if (obs !== 10'b0) begin
      fails++; $display("FAIL rst_mem_outputs obs=%b exp 0", obs);
    end
    step();
    reset = 1'b0;
    #1;
    tests++;
    if (state !== 3'd0 || instret_cnt !== 32'd0 || illegal !== 1'b0) begin
      fails++; $display("FAIL rst_mem_after st=%0d ret=%0d illegal=%b exp 0", state, instret_cnt, illegal);
    end
  endtask

  initial begin
    reset = 1'b1;
    apply(7'b0);
    test_reset();
    test_alu();
    test_load_wait();
    test_store_branch();
    test_timeout();
    test_ready_at_timeout();
    test_illegal_reset_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
